// File: rtl/wb_select_hilo_if.sv
// wb_select_hilo_if: source-select request and registered writeback result bus
//   in_data/sel/in_valid/in_ready : request side (master drives data, sel, valid)
//   out_data/out_err/out_valid/out_ready : result side (master drives ready)
interface wb_select_hilo_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 3
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_err;
    modport master (
        output in_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_err
    );
    modport slave (
        input  in_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_err
    );
endinterface

// File: rtl/wb_select_hilo.sv
// wb_select_hilo: writeback select among NUM_IN sources or HI/LO, registered behind valid/ready
//   clk, reset_n          : clock, synchronous active-low reset
//   bus (slave)           : request in_data/sel/in_valid/in_ready, result out_data/out_err/out_valid/out_ready
//   md_busy/md_done       : mult/div in flight / one-cycle result pulse loading HI/LO from md_hi/md_lo
//   mthi/mtlo/mt_data     : direct HI/LO writes
//   hi_q/lo_q             : current HI/LO
//   stall_cnt             : saturating count of HI/LO hazard stall cycles
module wb_select_hilo #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    wb_select_hilo_if.slave      bus,
    input  logic                 md_busy,
    input  logic                 md_done,
    input  logic [WIDTH-1:0]     md_hi,
    input  logic [WIDTH-1:0]     md_lo,
    input  logic                 mthi,
    input  logic                 mtlo,
    input  logic [WIDTH-1:0]     mt_data,
    output logic [WIDTH-1:0]     hi_q,
    output logic [WIDTH-1:0]     lo_q,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam logic [SEL_W-1:0] SEL_HI = SEL_W'(NUM_IN);
    localparam logic [SEL_W-1:0] SEL_LO = SEL_W'(NUM_IN + 1);
    logic [WIDTH-1:0] hi_next, lo_next, rd_data;
    logic             rd_err, hazard;
    // mult/div result wins over a same-cycle MTHI/MTLO
    assign hi_next = md_done ? md_hi : mthi ? mt_data : hi_q;
    assign lo_next = md_done ? md_lo : mtlo ? mt_data : lo_q;
    // HI/LO reads must wait until an in-flight mult/div delivers; the done cycle itself is bypassed
    assign hazard = bus.in_valid && (bus.sel == SEL_HI || bus.sel == SEL_LO) && md_busy && !md_done;
    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (int'(bus.sel) < NUM_IN) rd_data = bus.in_data[WIDTH*int'(bus.sel) +: WIDTH];
        else if (bus.sel == SEL_HI) rd_data = hi_next;
        else if (bus.sel == SEL_LO) rd_data = lo_next;
        else rd_err = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_err   <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            stall_cnt     <= '0;
        end else begin
            hi_q <= hi_next;
            lo_q <= lo_next;
            if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (bus.in_valid && bus.in_ready) begin
                bus.out_data  <= rd_data;
                bus.out_err   <= rd_err;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
